// File: rtl/uart_fifo_bridge.sv
// Byte-buffering bridge between the bus side and the simpleuart register port:
// a TX FIFO feeding reg_dat_we/di and an RX FIFO filled from reg_dat_re/do.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  uart_dat_we,
    output logic [31:0]           uart_dat_di,
    input  logic                  uart_dat_wait,
    output logic                  uart_dat_re,
    input  logic [31:0]           uart_dat_do
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;

    logic tx_push, tx_pop, rx_push, rx_pop, rx_byte_avail;

    assign tx_ready = (tx_count_q != FULL);
    assign rx_valid = (rx_count_q != '0);
    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
    assign rx_data  = rx_mem[rx_rd_ptr_q];

    assign tx_push = tx_valid && tx_ready;
    assign rx_pop  = rx_valid && rx_ready;

    // Strobes come only from registered counts, so a fresh push never pops in its own cycle.
    assign uart_dat_we = resetn && !flush && (tx_count_q != '0);
    assign uart_dat_di = (tx_count_q != '0) ? {24'd0, tx_mem[tx_rd_ptr_q]} : 32'd0;
    assign tx_pop      = uart_dat_we && !uart_dat_wait;

    // The core reports "no byte" as all ones; any zero upper field means a byte is waiting.
    assign rx_byte_avail = (uart_dat_do[31:8] == 24'd0);
    assign uart_dat_re   = resetn && !flush && rx_byte_avail && (rx_count_q != FULL);
    assign rx_push       = uart_dat_re;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase

        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because counts gate them.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (tx_push && (tx_wr_ptr_q == DEPTH_LOG2'(gi))) tx_mem[gi] <= tx_data;
            if (rx_push && (rx_wr_ptr_q == DEPTH_LOG2'(gi))) rx_mem[gi] <= uart_dat_do[7:0];
        end
    end

endmodule
